// File: rtl/regfile_wr_arbiter_if.sv
// RegFile write-port arbitration bus: WB and MC write requests, decode source
// lookups, and the shared write port with its status flags.
interface regfile_wr_arbiter_if;
    localparam int unsigned RegW  = 5;
    localparam int unsigned DataW = 32;
    localparam int unsigned CntW  = 2;

    logic             wb_valid;
    logic [RegW-1:0]  wb_rd;
    logic [DataW-1:0] wb_data;
    logic             mc_valid;
    logic [RegW-1:0]  mc_rd;
    logic [DataW-1:0] mc_data;
    logic             mc_ready;
    logic [RegW-1:0]  rs1;
    logic [RegW-1:0]  rs2;
    logic             busy1;
    logic             busy2;
    logic             RegWrite;
    logic [RegW-1:0]  WriteRegister;
    logic [DataW-1:0] WriteData;
    logic             stall_wb;
    logic             err;
    logic [CntW-1:0]  q_count;

    modport master (
        output wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data, rs1, rs2,
        input  mc_ready, busy1, busy2, RegWrite, WriteRegister, WriteData,
               stall_wb, err, q_count
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data, rs1, rs2,
        output mc_ready, busy1, busy2, RegWrite, WriteRegister, WriteData,
               stall_wb, err, q_count
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the single RegFile write port between the WB stage and a multi-cycle
// unit buffered in a 2-entry queue, with starvation stall and busy tracking.
module regfile_wr_arbiter (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int unsigned RegW  = 5;
    localparam int unsigned DataW = 32;
    localparam int unsigned CntW  = 2;
    localparam int unsigned WaitW = 3;
    localparam int unsigned Depth = 2;
    localparam logic [WaitW-1:0] WaitMax  = WaitW'(4);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(3);

    typedef struct packed {
        logic [RegW-1:0]  rd;
        logic [DataW-1:0] data;
    } entry_t;

    entry_t           headQ;
    entry_t           tailQ;
    logic [CntW-1:0]  qCount;
    logic [WaitW-1:0] waitCnt;
    logic             stallWb;
    logic             errFlag;

    logic             wbReq;
    logic             mcReady;
    logic             enq;
    logic             deq;
    logic             grantWb;
    logic             headValid;
    logic             tailValid;
    logic             regWrite;
    logic [RegW-1:0]  writeReg;
    logic [DataW-1:0] writeData;
    logic             busy1;
    logic             busy2;
    entry_t           mcEntry;

    // Request qualification and grant: the stall flag flips priority to the queue.
    always_comb begin
        wbReq     = bus.wb_valid && (bus.wb_rd != '0);
        mcReady   = reset && (qCount < CntW'(Depth));
        enq       = bus.mc_valid && mcReady && (bus.mc_rd != '0);
        headValid = (qCount != '0);
        tailValid = (qCount == CntW'(Depth));
        deq       = headValid && (stallWb || !wbReq);
        grantWb   = reset && wbReq && !deq;
        mcEntry   = '{rd: bus.mc_rd, data: bus.mc_data};
    end

    // Write-port mux; idle port drives zeros.
    always_comb begin
        regWrite  = 1'b0;
        writeReg  = '0;
        writeData = '0;
        if (deq) begin
            regWrite  = 1'b1;
            writeReg  = headQ.rd;
            writeData = headQ.data;
        end else if (grantWb) begin
            regWrite  = 1'b1;
            writeReg  = bus.wb_rd;
            writeData = bus.wb_data;
        end
    end

    // The head being dequeued this cycle still reports busy.
    always_comb begin
        busy1 = (bus.rs1 != '0) &&
                ((headValid && (headQ.rd == bus.rs1)) || (tailValid && (tailQ.rd == bus.rs1)));
        busy2 = (bus.rs2 != '0) &&
                ((headValid && (headQ.rd == bus.rs2)) || (tailValid && (tailQ.rd == bus.rs2)));
    end

    // Queue storage: head shifts from tail on dequeue; a new entry lands in the first free slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headQ  <= '0;
            tailQ  <= '0;
            qCount <= '0;
        end else begin
            if (deq) begin
                headQ <= tailQ;
            end
            if (enq) begin
                if (!headValid || (!tailValid && deq)) begin
                    headQ <= mcEntry;
                end else begin
                    tailQ <= mcEntry;
                end
            end
            if (enq && !deq) begin
                qCount <= qCount + CntW'(1);
            end else if (!enq && deq) begin
                qCount <= qCount - CntW'(1);
            end
        end
    end

    // Starvation tracking; the fourth consecutive denial raises stall_wb.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt <= '0;
            stallWb <= 1'b0;
            errFlag <= 1'b0;
        end else begin
            if (!headValid || deq) begin
                waitCnt <= '0;
            end else if (waitCnt != WaitMax) begin
                waitCnt <= waitCnt + WaitW'(1);
            end
            if (deq) begin
                stallWb <= 1'b0;
            end else if (headValid && (waitCnt == WaitLast)) begin
                stallWb <= 1'b1;
            end
            if (wbReq && stallWb && deq) begin
                errFlag <= 1'b1;
            end
        end
    end

    assign bus.mc_ready      = mcReady;
    assign bus.busy1         = busy1;
    assign bus.busy2         = busy2;
    assign bus.RegWrite      = regWrite;
    assign bus.WriteRegister = writeReg;
    assign bus.WriteData     = writeData;
    assign bus.stall_wb      = stallWb;
    assign bus.err           = errFlag;
    assign bus.q_count       = qCount;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: fixed vectors with hand-computed
// expectations covering queueing, priority, starvation, errors and reset.
module tb_regfile_wr_arbiter;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    regfile_wr_arbiter_if bus ();

    regfile_wr_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkPort(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
        checkVal({tag, ".we"},   32'(bus.RegWrite),      32'(we));
        checkVal({tag, ".rd"},   32'(bus.WriteRegister), 32'(rd));
        checkVal({tag, ".data"}, bus.WriteData,          d);
    endtask

    task automatic setWb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.wb_valid = v;
        bus.wb_rd    = rd;
        bus.wb_data  = d;
    endtask

    task automatic setMc(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.mc_valid = v;
        bus.mc_rd    = rd;
        bus.mc_data  = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        setWb(1'b1, 5'd3, 32'h1234);
        setMc(1'b0, 5'd0, 32'h0);
        bus.rs1 = 5'd5;
        bus.rs2 = 5'd0;
        #3;
        checkVal("rst.q_count",  32'(bus.q_count),  32'd0);
        checkVal("rst.stall",    32'(bus.stall_wb), 32'd0);
        checkVal("rst.err",      32'(bus.err),      32'd0);
        checkVal("rst.mc_ready", 32'(bus.mc_ready), 32'd0);
        checkVal("rst.busy1",    32'(bus.busy1),    32'd0);
        checkPort("rst.port", 1'b0, 5'd0, 32'h0);

        tick;
        setWb(1'b0, 5'd0, 32'h0);
        #2 reset = 1'b1;
        #1 checkVal("rel.mc_ready", 32'(bus.mc_ready), 32'd1);

        // Single MC request, no bypass
        tick;
        setMc(1'b1, 5'd5, 32'hA5A5_A5A5);
        #2;
        checkPort("t1.nobypass", 1'b0, 5'd0, 32'h0);
        checkVal("t1.q0", 32'(bus.q_count), 32'd0);
        tick;
        setMc(1'b0, 5'd0, 32'h0);
        #2;
        checkVal("t1.q1", 32'(bus.q_count), 32'd1);
        checkPort("t1.write", 1'b1, 5'd5, 32'hA5A5_A5A5);
        checkVal("t1.busy_deq", 32'(bus.busy1), 32'd1);
        tick;
        #2;
        checkVal("t1.qafter", 32'(bus.q_count), 32'd0);
        checkPort("t1.idle", 1'b0, 5'd0, 32'h0);
        checkVal("t1.busy_clr", 32'(bus.busy1), 32'd0);

        // Priority, fill and starvation stall
        tick;
        setWb(1'b1, 5'd9, 32'h99);
        setMc(1'b1, 5'd3, 32'h33);
        #2;
        checkPort("t2.c1", 1'b1, 5'd9, 32'h99);
        tick;
        setMc(1'b1, 5'd7, 32'h77);
        #2;
        checkPort("t2.c2", 1'b1, 5'd9, 32'h99);
        checkVal("t2.c2.q", 32'(bus.q_count), 32'd1);
        tick;
        setMc(1'b0, 5'd0, 32'h0);
        bus.rs1 = 5'd7;
        bus.rs2 = 5'd3;
        #2;
        checkVal("t2.full.q",     32'(bus.q_count),  32'd2);
        checkVal("t2.full.ready", 32'(bus.mc_ready), 32'd0);
        checkPort("t2.c3", 1'b1, 5'd9, 32'h99);
        checkVal("t2.busy1_rs7", 32'(bus.busy1), 32'd1);
        checkVal("t2.busy2_rs3", 32'(bus.busy2), 32'd1);
        bus.rs1 = 5'd0;
        #1 checkVal("t2.busy1_rs0", 32'(bus.busy1), 32'd0);
        tick;
        #2 checkVal("t2.c4.stall", 32'(bus.stall_wb), 32'd0);
        tick;
        #2;
        checkVal("t2.c5.stall", 32'(bus.stall_wb), 32'd0);
        checkPort("t2.c5", 1'b1, 5'd9, 32'h99);
        tick;
        setWb(1'b0, 5'd0, 32'h0);
        #2;
        checkVal("t2.c6.stall", 32'(bus.stall_wb), 32'd1);
        checkPort("t2.c6", 1'b1, 5'd3, 32'h33);
        tick;
        #2;
        checkVal("t2.c7.stall", 32'(bus.stall_wb), 32'd0);
        checkVal("t2.c7.q",     32'(bus.q_count),  32'd1);
        checkPort("t2.c7", 1'b1, 5'd7, 32'h77);
        checkVal("t2.c7.err", 32'(bus.err), 32'd0);
        tick;
        #2;
        checkVal("t2.c8.q", 32'(bus.q_count), 32'd0);
        checkPort("t2.c8", 1'b0, 5'd0, 32'h0);

        // Protocol violation during stall
        tick;
        setWb(1'b1, 5'd4, 32'h44);
        setMc(1'b1, 5'd12, 32'hC0DE);
        #2 checkPort("t3.e0", 1'b1, 5'd4, 32'h44);
        tick;
        setMc(1'b0, 5'd0, 32'h0);
        #2 checkVal("t3.e1.q", 32'(bus.q_count), 32'd1);
        tick;
        tick;
        tick;
        #2 checkVal("t3.e4.stall", 32'(bus.stall_wb), 32'd0);
        tick;
        #2;
        checkVal("t3.e5.stall", 32'(bus.stall_wb), 32'd1);
        checkPort("t3.e5", 1'b1, 5'd12, 32'hC0DE);
        checkVal("t3.e5.err", 32'(bus.err), 32'd0);
        tick;
        #2;
        checkVal("t3.e6.err",   32'(bus.err),      32'd1);
        checkVal("t3.e6.stall", 32'(bus.stall_wb), 32'd0);
        checkVal("t3.e6.q",     32'(bus.q_count),  32'd0);
        checkPort("t3.e6", 1'b1, 5'd4, 32'h44);
        setWb(1'b0, 5'd0, 32'h0);
        tick;
        tick;
        #2 checkVal("t3.sticky", 32'(bus.err), 32'd1);
        #1 reset = 1'b0;
        #1 checkVal("t3.err_rst", 32'(bus.err), 32'd0);
        reset = 1'b1;

        // Zero-register handling and simultaneous enqueue/dequeue
        tick;
        setMc(1'b1, 5'd0, 32'hDEAD);
        #2;
        checkVal("t4.ready", 32'(bus.mc_ready), 32'd1);
        checkPort("t4.z0", 1'b0, 5'd0, 32'h0);
        tick;
        setMc(1'b0, 5'd0, 32'h0);
        #2;
        checkVal("t4.z1.q", 32'(bus.q_count), 32'd0);
        checkPort("t4.z1", 1'b0, 5'd0, 32'h0);
        tick;
        setMc(1'b1, 5'd2, 32'h22);
        #2 checkPort("t4.enq", 1'b0, 5'd0, 32'h0);
        tick;
        setMc(1'b1, 5'd6, 32'h66);
        setWb(1'b1, 5'd0, 32'hFFFF);
        #2;
        checkPort("t4.wbzero", 1'b1, 5'd2, 32'h22);
        checkVal("t4.wbzero.q", 32'(bus.q_count), 32'd1);
        tick;
        setMc(1'b0, 5'd0, 32'h0);
        setWb(1'b0, 5'd0, 32'h0);
        #2;
        checkVal("t4.swap.q", 32'(bus.q_count), 32'd1);
        checkPort("t4.swap", 1'b1, 5'd6, 32'h66);
        tick;
        #2 checkVal("t4.end.q", 32'(bus.q_count), 32'd0);

        // Reset mid-operation with a full queue
        tick;
        setMc(1'b1, 5'd10, 32'hA);
        setWb(1'b1, 5'd1, 32'h1);
        tick;
        setMc(1'b1, 5'd11, 32'hB);
        tick;
        setMc(1'b0, 5'd0, 32'h0);
        setWb(1'b0, 5'd0, 32'h0);
        bus.rs1 = 5'd10;
        #2;
        checkVal("t5.q2", 32'(bus.q_count), 32'd2);
        checkPort("t5.pre", 1'b1, 5'd10, 32'hA);
        checkVal("t5.busy_pre", 32'(bus.busy1), 32'd1);
        #1 reset = 1'b0;
        #1;
        checkVal("t5.rst.q", 32'(bus.q_count), 32'd0);
        checkPort("t5.rst", 1'b0, 5'd0, 32'h0);
        checkVal("t5.rst.ready", 32'(bus.mc_ready), 32'd0);
        checkVal("t5.rst.busy",  32'(bus.busy1),    32'd0);
        tick;
        #2 checkVal("t5.hold.q", 32'(bus.q_count), 32'd0);
        #1 reset = 1'b1;
        #1 checkVal("t5.rel.ready", 32'(bus.mc_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            #2;
            checkPort("t5.after", 1'b0, 5'd0, 32'h0);
            checkVal("t5.after.q", 32'(bus.q_count), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have a single write-port grant stage sharing the RegFile write port between the pipeline WB stage and a multi-cycle unit (MC).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low; low forces the reset state immediately.
REQ-005 wb_valid / wb_rd / wb_data  input  1/5/32  WB write request; no backpressure.
REQ-006 mc_valid / mc_rd / mc_data  input  1/5/32  MC write request; valid/ready handshake.
REQ-007 mc_ready  output  1  queue can accept: high when q_count<2.
REQ-008 rs1 / rs2  input  5/5  decode-stage source registers.
REQ-009 busy1 / busy2  output  1/1  source register has a pending queued MC write.
REQ-010 RegWrite / WriteRegister / WriteData  output  1/5/32  drive the RegFile write port; combinational.
REQ-011 stall_wb  output  1  registered; requests that the pipeline hold WB.
REQ-012 err  output  1  sticky protocol-violation flag.
REQ-013 q_count  output  2  queue occupancy, 0..2.

Function
REQ-014 The queue SHALL be a 2-entry FIFO of {rd, data}.
- Enqueue on mc_valid && mc_ready && mc_rd!=0.
- mc_valid && mc_ready && mc_rd==0: handshake completes, entry discarded, q_count unchanged.
REQ-015 There SHALL be no bypass: an entry enqueued in cycle N is first grantable in cycle N+1.
REQ-016 wb_req = wb_valid && wb_rd!=0. wb_valid with wb_rd==0 SHALL count as no request.
REQ-017 Grant with stall_wb==0:
- wb_req: port <= WB.
- else q_count>0: port <= queue head, dequeued at clock edge.
- else RegWrite=0.
REQ-018 Grant with stall_wb==1: queue head SHALL win; WB only if q_count==0.
REQ-019 When RegWrite==0, WriteRegister and WriteData SHALL be 0.
REQ-020 Enqueue and dequeue in the same cycle SHALL leave q_count unchanged (only reachable with q_count==1).
REQ-021 wait_cnt (3 bits, saturating at 4):
- increments each cycle q_count>0 and the head is not granted;
- clears on dequeue or when q_count==0.
REQ-022 stall_wb SHALL:
- set at the edge where wait_cnt goes from 3 to 4 (head denied 4 consecutive cycles);
- clear at the edge that dequeues the head.
REQ-023 If wb_req==1 while stall_wb==1 and the queue is granted, that WB write SHALL be dropped and err set; err stays 1 until reset.
REQ-024 busy1 SHALL be (rs1!=0) && (rs1 matches rd of any valid queue entry); busy2 likewise for rs2. Combinational; the entry being dequeued this cycle still counts as busy.
- WB is not tracked here; the RegFile write-through covers same-cycle WB.
REQ-025 WAW ordering between queue and WB SHALL be the pipeline's responsibility via busy1/busy2; the arbiter does not reorder or merge.

Reset
REQ-026 While reset==0, SHALL force:
- q_count=0, queue entries invalid, wait_cnt=0;
- stall_wb=0, err=0;
- RegWrite=0, WriteRegister=0, WriteData=0;
- mc_ready=0, busy1=busy2=0.
REQ-027 Reset asserted mid-operation SHALL discard queued writes without any port write. mc_ready SHALL rise in the first cycle after deassertion.

Verification
REQ-028 Reset, then single MC request: mc_valid=1, mc_rd=5, mc_data=0xA5A5A5A5, wb idle -> q_count=1 next cycle; following cycle RegWrite=1, WriteRegister=5, WriteData=0xA5A5A5A5; q_count=0 after.
REQ-029 Priority and fill: queue rd=3 then rd=7 while wb_req=1 with rd=9 each cycle -> port shows rd=9 every cycle; mc_ready=0 at q_count=2; busy1=1 for rs1=7; busy1=0 for rs1=0.
REQ-030 Starvation: q_count=1, wb_req=1 continuously -> stall_wb=1 after the 4th denied cycle; next cycle port writes the head; stall_wb=0 after that edge; err=0 if wb_valid dropped during stall.
REQ-031 Protocol violation: hold wb_req=1 (rd=4) during a stall_wb cycle -> queue head written, rd=4 write absent, err=1 and stays 1 until reset.
REQ-032 Zero-register handling: mc_rd=0 handshake -> q_count stays 0, no port write; wb_valid=1 with wb_rd=0 and q_count=1 -> queue head granted that cycle.
REQ-033 Reset mid-operation: q_count=2, assert reset=0 between edges -> q_count=0 and RegWrite=0 immediately; no queued write appears after release.
